// File: rtl/sync_mod_counter_div.sv
// Fully synchronous modulo-(TERM+1) up/down counter with load, terminal-count
// flag and a 50%-duty divided output that toggles on every wrap.
module sync_mod_counter_div #(
  parameter int                WIDTH    = 4,
  parameter logic [WIDTH-1:0]  TERM_RST = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic [WIDTH-1:0] TERM,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             DIV_OUT
);

  // TERM_RST only documents the usual full-range tie-off for TERM.
  if (TERM_RST == '0) begin : g_term_rst_zero
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             wrap;

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    wrap  = 1'b0;
    if (LOAD) begin
      cnt_d = LOAD_VAL;
    end else if (EN) begin
      if (UP) begin
        // Anything at or above TERM (e.g. after a load or TERM change) wraps to 0.
        if (cnt_q >= TERM) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d = TERM;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
    if (wrap) begin
      div_d = ~div_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign Q       = cnt_q;
  assign DIV_OUT = div_q;
  assign TC      = EN & (UP ? (cnt_q == TERM) : (cnt_q == '0));

endmodule

// File: tb/tb_sync_mod_counter_div.sv
// Self-checking bench: directed scenarios plus random stimulus against an
// integer reference model of the modulo counter and divided output.
module tb_sync_mod_counter_div;

  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             EN = 1'b0;
  logic             UP = 1'b1;
  logic             LOAD = 1'b0;
  logic [WIDTH-1:0] LOAD_VAL = '0;
  logic [WIDTH-1:0] TERM = '1;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             DIV_OUT;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int m_q   = 0;
  int m_div = 0;

  sync_mod_counter_div #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .TERM(TERM), .Q(Q), .TC(TC), .DIV_OUT(DIV_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d (model q=%0d)", tag, obs, exp, m_q);
    end
  endtask

  // One clock: drive inputs on the falling edge, check TC before the rising
  // edge, advance the model, check Q/DIV_OUT at the next falling edge.
  task automatic cyc(input bit rst, input bit load, input int lv,
                     input bit en, input bit up, input int term);
    int exp_tc;
    RST = rst; LOAD = load; LOAD_VAL = lv[WIDTH-1:0];
    EN = en; UP = up; TERM = term[WIDTH-1:0];
    #1;
    exp_tc = en ? (up ? int'(m_q == term) : int'(m_q == 0)) : 0;
    check("tc", {31'b0, TC}, exp_tc);
    @(posedge CLK);
    if (rst) begin
      m_q = 0; m_div = 0;
    end else if (load) begin
      m_q = lv;
    end else if (en) begin
      if (up) begin
        if (m_q > term) begin
          m_q = 0; m_div = 1 - m_div;
        end else begin
          if (m_q == term) m_div = 1 - m_div;
          m_q = (m_q + 1) % (term + 1);
        end
      end else begin
        if (m_q > term) begin
          m_q = m_q - 1;
        end else begin
          if (m_q == 0) m_div = 1 - m_div;
          m_q = (m_q + term) % (term + 1);
        end
      end
    end
    @(negedge CLK);
    check("q", {28'b0, Q}, m_q);
    check("div_out", {31'b0, DIV_OUT}, m_div);
  endtask

  initial begin
    int div_high;
    $display("[TB] start");
    // Initial reset: bring DUT out of X before model-based checking.
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_q", {28'b0, Q}, 0);
    check("reset_div", {31'b0, DIV_OUT}, 0);

    // 1: full range up count
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1, 1, MAXV);

    // 2: TERM=9 up; also count DIV_OUT high cycles over one full period
    cyc(1, 0, 0, 0, 1, 9);
    div_high = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, 1, 1, 9);
      if (i >= 20) div_high += int'(DIV_OUT);
    end
    check("div_high_per_20", div_high, 10);

    // 3: TERM=9 down from reset
    cyc(1, 0, 0, 0, 0, 9);
    for (int i = 0; i < 25; i++) cyc(0, 0, 0, 1, 0, 9);

    // 4: load above TERM then count up wraps; LOAD with RST gives 0
    cyc(0, 1, 12, 1, 1, 9);
    check("load_q12", {28'b0, Q}, 12);
    cyc(0, 0, 0, 1, 1, 9);
    check("wrap_from_12", {28'b0, Q}, 0);
    cyc(0, 1, 12, 1, 1, 9);
    cyc(1, 1, 12, 1, 1, 9);
    check("rst_beats_load", {28'b0, Q}, 0);

    // 5: enable gating at Q=5 and at Q=9
    cyc(0, 1, 5, 0, 1, 9);
    cyc(0, 0, 0, 1, 1, 9);
    cyc(0, 0, 0, 0, 1, 9);
    cyc(0, 0, 0, 0, 1, 9);
    cyc(0, 0, 0, 1, 1, 9);
    check("en_gate_q7", {28'b0, Q}, 7);
    cyc(0, 1, 9, 0, 1, 9);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 9);

    // 6: TERM=0 in both directions, then reset mid-count at Q=7
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 9);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 1, 9);
    check("pre_rst_q7", {28'b0, Q}, 7);
    cyc(1, 0, 0, 1, 1, 9);

    // Down count from above TERM, then random traffic
    cyc(0, 1, 14, 0, 0, 9);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 9);
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
          int'($urandom_range(0, MAXV)), ($urandom_range(0, 4) != 0),
          ($urandom_range(0, 1) == 1),
          (i % 50 < 25) ? int'($urandom_range(0, MAXV)) : ((i / 50) % 16));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
